wb_timer_slave: RTL and testbench

- Wishbone classic slave with an 8-bit data path. It is a programmable down-counting timer that hangs on the shared wishbone bus next to the memory slave.
- It decodes the low address bits, answers with ack_o or err_o, and raises a level interrupt request.
- irq_o drives one bit of the CPU interrupciones vector, so the timer feeds the CPU interrupt input directly.
- Sits on the same syscon-generated clock and reset as the other wishbone slaves.

---
 rtl/wb_timer_pkg.sv | 26 ++
 rtl/timer_prescaler.sv | 39 +++
 rtl/wb_timer_slave.sv | 151 +++++++++++++++
 tb/tb_wb_timer_slave.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_timer_pkg.sv
// Shared definitions for the wishbone timer slave: register offsets,
// CTRL/STATUS bit positions and the CTRL register layout.
package wb_timer_pkg;

  localparam int unsigned ADR_CTRL   = 0;
  localparam int unsigned ADR_PRESC  = 1;
  localparam int unsigned ADR_RELOAD = 2;
  localparam int unsigned ADR_STATUS = 3;
  localparam int unsigned ADR_COUNT  = 4;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_AUTO   = 1;
  localparam int unsigned CTRL_IE     = 2;
  localparam int unsigned STATUS_FLAG = 0;

  localparam int unsigned CTRL_W  = 3;
  localparam int unsigned PRESC_W = 8;

  // CTRL register, bit 0 = en, bit 1 = auto_rl, bit 2 = ie
  typedef struct packed {
    logic ie;
    logic auto_rl;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the wishbone timer.
// Ports: clk, reset (async, active high), en (count enable),
//        presc (terminal value), clr (restart from 0),
//        tick (one-cycle pulse when the counter equals presc while enabled).
module timer_prescaler
  import wb_timer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  assign tick = en & (cnt_q == presc);

  // Count 0..presc, held at 0 while disabled
  always_comb begin
    cnt_d = cnt_q;
    if (!en || clr || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_timer_slave.sv
// Wishbone classic slave: programmable down-counting timer with a level IRQ.
// Ports: clk, reset (async, active high); adr_i/dat_i/we_i/stb_i/cyc_i from
//        the master; dat_o/ack_o/err_o/rty_o terminations (registered, one
//        cycle); irq_o = FLAG & IE (registered).
module wb_timer_slave
  import wb_timer_pkg::*;
#(
  parameter int unsigned ADR_W = 4,
  parameter int unsigned DAT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADR_W-1:0] adr_i,
  input  logic [DAT_W-1:0] dat_i,
  output logic [DAT_W-1:0] dat_o,
  input  logic             we_i,
  input  logic             stb_i,
  input  logic             cyc_i,
  output logic             ack_o,
  output logic             err_o,
  output logic             rty_o,
  output logic             irq_o
);

  ctrl_t            ctrl_q, ctrl_d;
  logic [DAT_W-1:0] presc_q, presc_d;
  logic [DAT_W-1:0] reload_q, reload_d;
  logic [DAT_W-1:0] count_q, count_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic             flag_q, flag_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             irq_q, irq_d;

  logic             req;
  logic             bad;
  logic             tick;
  logic             clr;
  logic             expire;

  // A request is only taken while no termination is pending
  assign req = cyc_i & stb_i & ~ack_q & ~err_q;
  assign bad = (adr_i > ADR_W'(ADR_COUNT)) | (we_i & (adr_i == ADR_W'(ADR_COUNT)));

  timer_prescaler u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q.en),
    .presc (presc_q),
    .clr   (clr),
    .tick  (tick)
  );

  // Counter update first, then bus write so that CTRL writes override a
  // one-shot disable; W1C of FLAG loses against a same-cycle expiry.
  always_comb begin
    ctrl_d   = ctrl_q;
    presc_d  = presc_q;
    reload_d = reload_q;
    count_d  = count_q;
    flag_d   = flag_q;
    dat_d    = '0;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    clr      = 1'b0;
    expire   = 1'b0;

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - DAT_W'(1);
      end else begin
        expire = 1'b1;
        flag_d = 1'b1;
        if (ctrl_q.auto_rl) begin
          count_d = reload_q;
        end else begin
          ctrl_d.en = 1'b0;
          count_d   = '0;
        end
      end
    end

    if (req) begin
      ack_d = ~bad;
      err_d = bad;
      if (!bad && !we_i) begin
        case (adr_i)
          ADR_W'(ADR_CTRL):   dat_d = DAT_W'(ctrl_q);
          ADR_W'(ADR_PRESC):  dat_d = presc_q;
          ADR_W'(ADR_RELOAD): dat_d = reload_q;
          ADR_W'(ADR_STATUS): dat_d = DAT_W'(flag_q);
          ADR_W'(ADR_COUNT):  dat_d = count_q;
          default:            dat_d = '0;
        endcase
      end
      if (!bad && we_i) begin
        case (adr_i)
          ADR_W'(ADR_CTRL): begin
            ctrl_d = ctrl_t'(dat_i[CTRL_W-1:0]);
            // Rising EN restarts the count from RELOAD
            if (!ctrl_q.en && dat_i[CTRL_EN]) begin
              count_d = reload_q;
              clr     = 1'b1;
            end
          end
          ADR_W'(ADR_PRESC):  presc_d  = dat_i;
          ADR_W'(ADR_RELOAD): reload_d = dat_i;
          ADR_W'(ADR_STATUS): begin
            if (dat_i[STATUS_FLAG] && !expire) begin
              flag_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end

    irq_d = flag_d & ctrl_d.ie;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= '0;
      presc_q  <= '0;
      reload_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      dat_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      dat_q    <= dat_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
    end
  end

  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;
  assign rty_o = 1'b0;
  assign irq_o = irq_q;

endmodule

// File: tb/tb_wb_timer_slave.sv
// Bench for wb_timer_slave: cycle model of the register map and timer
// rules checked every cycle, plus directed scenarios with literal results.
module tb_wb_timer_slave;

  localparam int unsigned ADR_W = 4;
  localparam int unsigned DAT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [ADR_W-1:0] adr_i = '0;
  logic [DAT_W-1:0] dat_i = '0;
  logic [DAT_W-1:0] dat_o;
  logic             we_i = 1'b0;
  logic             stb_i = 1'b0;
  logic             cyc_i = 1'b0;
  logic             ack_o, err_o, rty_o, irq_o;

  int errors = 0;
  int checks = 0;

  wb_timer_slave #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .we_i  (we_i),
    .stb_i (stb_i),
    .cyc_i (cyc_i),
    .ack_o (ack_o),
    .err_o (err_o),
    .rty_o (rty_o),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_ctrl = 0, m_presc = 0, m_reload = 0, m_count = 0, m_flag = 0, m_phase = 0;
  int m_ack = 0, m_err = 0, m_irq = 0, m_dat = 0;
  int n_ctrl, n_count, n_flag, n_phase, a, wd;
  bit req, bad, tick, expire;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ctrl = 0; m_presc = 0; m_reload = 0; m_count = 0; m_flag = 0; m_phase = 0;
      m_ack = 0; m_err = 0; m_irq = 0; m_dat = 0;
    end else begin
      a   = int'(adr_i);
      wd  = int'(dat_i);
      req = cyc_i && stb_i && (m_ack == 0) && (m_err == 0);
      bad = (a > 4) || (we_i && a == 4);
      n_ctrl = m_ctrl; n_count = m_count; n_flag = m_flag; expire = 1'b0;
      // one tick every PRESC+1 enabled cycles
      tick    = ((m_ctrl & 1) != 0) && (m_phase == m_presc);
      n_phase = (tick || (m_ctrl & 1) == 0) ? 0 : m_phase + 1;
      if (tick) begin
        if (m_count != 0) n_count = m_count - 1;
        else begin
          expire = 1'b1;
          n_flag = 1;
          if ((m_ctrl & 2) != 0) n_count = m_reload;
          else n_ctrl = m_ctrl & 6;
        end
      end
      m_dat = 0;
      if (req && !bad && !we_i) begin
        case (a)
          0: m_dat = m_ctrl;
          1: m_dat = m_presc;
          2: m_dat = m_reload;
          3: m_dat = m_flag;
          default: m_dat = m_count;
        endcase
      end
      if (req && !bad && we_i) begin
        case (a)
          0: begin
            if ((m_ctrl & 1) == 0 && (wd & 1) != 0) begin
              n_count = m_reload;
              n_phase = 0;
            end
            n_ctrl = wd & 7;
          end
          1: m_presc = wd;
          2: m_reload = wd;
          3: if ((wd & 1) != 0 && !expire) n_flag = 0;
          default: ;
        endcase
      end
      m_ack   = (req && !bad) ? 1 : 0;
      m_err   = (req && bad) ? 1 : 0;
      m_ctrl  = n_ctrl;
      m_count = n_count;
      m_flag  = n_flag;
      m_phase = n_phase;
      m_irq   = (n_flag != 0 && (n_ctrl & 4) != 0) ? 1 : 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!reset) begin
      chk("cyc_ack", int'(ack_o), m_ack);
      chk("cyc_err", int'(err_o), m_err);
      chk("cyc_rty", int'(rty_o), 0);
      chk("cyc_irq", int'(irq_o), m_irq);
      if (m_ack != 0 || m_err != 0) chk("cyc_dat", int'(dat_o), m_dat);
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus(input int adr, input bit w, input int d,
                     output int rd, output bit ak, output bit er, output int lat);
    adr_i = ADR_W'(adr);
    dat_i = DAT_W'(d);
    we_i  = w;
    cyc_i = 1'b1;
    stb_i = 1'b1;
    lat = 0; ak = 1'b0; er = 1'b0; rd = 0;
    while (lat < 8 && !(ak || er)) begin
      @(posedge clk); #1;
      lat++;
      ak = ack_o;
      er = err_o;
      rd = int'(dat_o);
    end
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    chk("bus_term", int'(ak | er), 1);
  endtask

  task automatic wr(input int adr, input int d);
    int rd, lat; bit ak, er;
    bus(adr, 1'b1, d, rd, ak, er, lat);
    chk("wr_ack", int'(ak), 1);
  endtask

  task automatic rd_chk(input string name, input int adr, input int exp);
    int rd, lat; bit ak, er;
    bus(adr, 1'b0, 0, rd, ak, er, lat);
    chk({name, "_ack"}, int'(ak), 1);
    chk(name, rd, exp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_irq();
    int n = 0;
    while (!irq_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_irq", int'(irq_o), 1);
  endtask

  // All registers read 0 with single-cycle acks
  task automatic reset_reads();
    int rd, lat; bit ak, er;
    for (int i = 0; i < 5; i++) begin
      bus(i, 1'b0, 0, rd, ak, er, lat);
      chk("rst_rd_ack", int'(ak), 1);
      chk("rst_rd_dat", rd, 0);
      chk("rst_rd_lat", lat, 1);
      cycles(1);
    end
    chk("rst_irq", int'(irq_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rd, lat, pat;
    bit ak, er;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", int'(ack_o), 0);
    chk("reset_err", int'(err_o), 0);
    chk("reset_irq", int'(irq_o), 0);
    chk("reset_dat", int'(dat_o), 0);
    reset = 1'b0;
    reset_reads();

    // Auto-reload: PRESC=1, RELOAD=3, period 8
    wr(1, 1);
    wr(2, 3);
    wr(0, 7);
    for (int i = 0; i < 4; i++) begin
      rd_chk("ar_count", 4, 3 - i);
      chk("ar_irq_edge", int'(irq_o), (i == 3) ? 1 : 0);
    end
    wr(3, 1);
    chk("ar_w1c", int'(irq_o), 0);
    for (int i = 1; i <= 6; i++) begin
      cycles(1);
      chk("ar_period", int'(irq_o), (i == 6) ? 1 : 0);
    end
    // W1C landing exactly on the next expiry
    cycles(7);
    wr(3, 1);
    chk("w1c_race", int'(irq_o), 1);
    wr(3, 1);
    chk("w1c_clear", int'(irq_o), 0);
    wait_irq();
    wr(3, 0);
    chk("w1c_zero", int'(irq_o), 1);
    rd_chk("w1c_status", 3, 1);

    // Asynchronous reset in the middle of a running count
    cycles(3);
    #2 reset = 1'b1;
    #1;
    chk("async_irq", int'(irq_o), 0);
    chk("async_ack", int'(ack_o), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    reset_reads();

    // One-shot: PRESC=0, RELOAD=2, CTRL=EN|IE
    wr(1, 0);
    wr(2, 2);
    wr(0, 5);
    for (int i = 1; i <= 3; i++) begin
      cycles(1);
      chk("os_edge", int'(irq_o), (i == 3) ? 1 : 0);
    end
    rd_chk("os_ctrl", 0, 4);
    rd_chk("os_count", 4, 0);
    cycles(10);
    chk("os_hold", int'(irq_o), 1);
    wr(3, 1);
    chk("os_clr", int'(irq_o), 0);
    cycles(10);
    chk("os_quiet", int'(irq_o), 0);
    rd_chk("os_count2", 4, 0);

    // Error terminations
    bus(7, 1'b0, 0, rd, ak, er, lat);
    chk("err7_err", int'(er), 1);
    chk("err7_ack", int'(ak), 0);
    chk("err7_dat", rd, 0);
    cycles(1);
    chk("err_pulse", int'(err_o), 0);
    bus(4, 1'b1, 8'h55, rd, ak, er, lat);
    chk("errw4_err", int'(er), 1);
    chk("errw4_ack", int'(ak), 0);
    rd_chk("errw4_count", 4, 0);
    bus(9, 1'b1, 8'hFF, rd, ak, er, lat);
    chk("errw9_err", int'(er), 1);
    rd_chk("errw9_presc", 1, 0);
    rd_chk("errw9_reload", 2, 2);

    // Strobe held 4 cycles: acks on cycles 1 and 3 only
    cycles(1);
    adr_i = ADR_W'(2);
    we_i  = 1'b0;
    cyc_i = 1'b1;
    stb_i = 1'b1;
    pat = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack_o) pat = pat | (1 << i);
    end
    cyc_i = 1'b0;
    stb_i = 1'b0;
    chk("hold_stb_pattern", pat, 5);

    // IE masking: expiry with IE=0 then enable IE
    wr(2, 0);
    wr(0, 1);
    cycles(3);
    rd_chk("ie_status", 3, 1);
    chk("ie_masked", int'(irq_o), 0);
    wr(0, 4);
    chk("ie_unmask", int'(irq_o), 1);

    // RELOAD=0, PRESC=0 auto: expiry every cycle, W1C never wins
    wr(0, 7);
    cycles(2);
    wr(3, 1);
    rd_chk("every_cycle_flag", 3, 1);
    wr(0, 0);
    wr(3, 1);
    rd_chk("stopped_flag", 3, 0);
    cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
